// File: rtl/seek_z_mul_pkg.sv
// Shared definitions for the seek_z_mul multiplier stage.
//
// Holds the default base data width and the FSM state encoding so that
// neighbouring seek_* stages can agree on both.
package seek_z_mul_pkg;

    // Base data width; operands are DW+1 bits, the product 2*DW+2 bits.
    localparam int DATAWIDTH = 16;

    // Width of the shift-add step counter (covers up to 32 steps).
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : seek_z_mul_pkg

// File: rtl/seek_z_mul.sv
// seek_z_mul -- sequential radix-2 shift-add unsigned multiplier.
//
// A request on en in IDLE latches a and b, then DW+1 shift-add steps run
// (one per clock) and the exact product is presented on z together with a
// one-cycle rdy pulse. z holds its value until the next completion.
//
// Ports:
//   clk   in   1        single clock, rising edge
//   rst   in   1        synchronous, active-high reset
//   en    in   1        start request, sampled only in IDLE
//   a     in   DW+1     unsigned multiplicand
//   b     in   DW+1     unsigned multiplier
//   z     out  2*DW+2   registered product a*b
//   rdy   out  1        registered one-cycle pulse marking z valid
//   busy  out  1        high from the cycle after acceptance through DONE
module seek_z_mul
    import seek_z_mul_pkg::*;
#(
    parameter int DW = DATAWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DW:0]       a,
    input  logic [DW:0]       b,
    output logic [2*DW+1:0]   z,
    output logic              rdy,
    output logic              busy
);

    localparam int ZW = 2 * DW + 2;

    // Index of the final step; RUN covers steps 0..DW (DW+1 edges).
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DW);

    state_e             state_q, state_d;
    logic [DW:0]        a_q, a_d;
    logic [DW:0]        b_q, b_d;
    logic [ZW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ZW-1:0]      z_q, z_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    // Partial product for the current step: the multiplicand shifted to the
    // weight of the multiplier bit currently sitting in b_q[0].
    logic [ZW-1:0]      addend;
    logic [ZW-1:0]      step_sum;

    always_comb begin
        addend   = b_q[0] ? (ZW'(a_q) << cnt_q) : '0;
        step_sum = acc_q + addend;
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        rdy_d   = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (en) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                acc_d = step_sum;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                // The last step publishes its own sum directly so the
                // product appears on the same edge that completes it.
                if (cnt_q == LAST_STEP) begin
                    z_d     = step_sum;
                    rdy_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the operand and accumulator registers are reset too, so an
    // aborted operation leaves no stale data behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign z    = z_q;
    assign rdy  = rdy_q;
    assign busy = busy_q;

endmodule : seek_z_mul
